// File: rtl/ctr_run_scheduler_if.sv
// Handshake bundle between the requesters/counter side (master) and the run scheduler (slave).
interface ctr_run_scheduler_if #(
  parameter int N       = 4,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*N-1:0] len;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 timeout;
  logic                 busy;
  logic                 ctr_clr;
  logic                 ctr_en;
  logic [N-1:0]         ctr_count;

  modport master (
    output req, len, ctr_count,
    input  gnt, done, timeout, busy, ctr_clr, ctr_en
  );

  modport slave (
    input  req, len, ctr_count,
    output gnt, done, timeout, busy, ctr_clr, ctr_en
  );
endinterface

// File: rtl/ctr_run_scheduler.sv
// Round-robin scheduler that lends one shared up-counter to NUM_REQ requesters for counting runs.
// Optional watchdog on stuck counters: define CTR_RUN_SCHED_TIMEOUT_EN.
module ctr_run_scheduler #(
  parameter int N       = 4,
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  ctr_run_scheduler_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    target_q, target_d;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   idx_next;
  logic            pick_found;
  logic            at_target;

`ifdef CTR_RUN_SCHED_TIMEOUT_EN
  logic [N:0]      wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            wd_expired;

  // wd_q holds the number of RUN cycles already spent; the 2^N+1-th one gives up.
  assign wd_expired  = (wd_q == {1'b1, {N{1'b0}}});
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign at_target = (bus.ctr_count == target_q);
  assign idx_next  = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);

  // First requester at or after rr_ptr_q, wrapping past the top.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && bus.req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      target_q  <= '0;
`ifdef CTR_RUN_SCHED_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      target_q  <= target_d;
`ifdef CTR_RUN_SCHED_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    target_d  = target_q;
`ifdef CTR_RUN_SCHED_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d    = pick_idx;
          target_d = bus.len[int'(pick_idx)*N +: N];
          state_d  = CLR;
        end
      end
      CLR: begin
        state_d = RUN;
`ifdef CTR_RUN_SCHED_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      RUN: begin
        // A dropped request wins over a target hit in the same cycle.
        if (!bus.req[idx_q]) begin
          state_d  = IDLE;
          rr_ptr_d = idx_next;
        end else if (at_target) begin
          state_d  = DONE;
        end
`ifdef CTR_RUN_SCHED_TIMEOUT_EN
        else if (wd_expired) begin
          state_d   = IDLE;
          rr_ptr_d  = idx_next;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + (N+1)'(1);
        end
`endif
      end
      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = idx_next;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt     = '0;
    bus.done    = '0;
    bus.ctr_clr = 1'b0;
    bus.ctr_en  = 1'b0;
    bus.busy    = (state_q != IDLE);
    case (state_q)
      CLR: begin
        bus.gnt[idx_q] = 1'b1;
        bus.ctr_clr    = 1'b1;
      end
      RUN: begin
        bus.gnt[idx_q] = 1'b1;
        bus.ctr_en     = !at_target;
      end
      DONE: begin
        bus.gnt[idx_q]  = 1'b1;
        bus.done[idx_q] = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ctr_run_scheduler.sv
// Directed bench for ctr_run_scheduler with a behavioural counter (clr -> 0, else en -> +1).
module tb_ctr_run_scheduler;
  localparam int N       = 4;
  localparam int NUM_REQ = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ctr_run_scheduler_if #(.N(N), .NUM_REQ(NUM_REQ)) bus ();

  ctr_run_scheduler #(.N(N), .NUM_REQ(NUM_REQ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic [N-1:0] cnt   = '0;
  logic         stuck = 1'b0;
  always @(posedge clk) begin
    if (bus.ctr_clr)               cnt <= '0;
    else if (bus.ctr_en && !stuck) cnt <= cnt + 1'b1;
  end
  assign bus.ctr_count = cnt;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    bus.len[i*N +: N] = N'(v);
  endtask

  // Steps cycles from the current one (cycle 0) and records key events by cycle number.
  task automatic run_watch(input int max_cyc, output int en_cnt, output int gnt_cyc,
                           output int gnt_val, output int clr_cyc, output int done_cyc,
                           output int done_val, output int cnt_done, output int tmo_cyc);
    en_cnt = 0; gnt_cyc = -1; gnt_val = 0; clr_cyc = -1;
    done_cyc = -1; done_val = 0; cnt_done = -1; tmo_cyc = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      if (bus.ctr_en) en_cnt++;
      if (gnt_cyc < 0 && bus.gnt != 0) begin gnt_cyc = c; gnt_val = int'(bus.gnt); end
      if (clr_cyc < 0 && bus.ctr_clr) clr_cyc = c;
      if (tmo_cyc < 0 && bus.timeout) tmo_cyc = c;
      if (bus.done != 0) begin
        done_cyc = c; done_val = int'(bus.done); cnt_done = int'(cnt);
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int en, gc, gv, cc, dc, dv, cd, tc;
  int hit;

  initial begin
    bus.req = '0;
    bus.len = '0;
    reset_n = 1'b0;
    repeat (2) tick();
    check("rst_gnt",     int'(bus.gnt),     0);
    check("rst_done",    int'(bus.done),    0);
    check("rst_busy",    int'(bus.busy),    0);
    check("rst_clr",     int'(bus.ctr_clr), 0);
    check("rst_en",      int'(bus.ctr_en),  0);
    check("rst_timeout", int'(bus.timeout), 0);
    reset_n = 1'b1;
    tick();

    // 1: single run of length 5
    set_len(0, 5);
    bus.req = 4'b0001;
    run_watch(20, en, gc, gv, cc, dc, dv, cd, tc);
    check("t1_gnt_cyc",  gc, 1);
    check("t1_gnt",      gv, 1);
    check("t1_clr_cyc",  cc, 1);
    check("t1_en_cnt",   en, 5);
    check("t1_done_cyc", dc, 8);
    check("t1_done",     dv, 1);
    check("t1_count",    cd, 5);
    bus.req = '0;
    tick();
    check("t1_idle_busy", int'(bus.busy), 0);
    check("t1_idle_gnt",  int'(bus.gnt),  0);

    // 2: round robin over all four with wrap back to 0
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) set_len(i, 2);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_watch(20, en, gc, gv, cc, dc, dv, cd, tc);
      check($sformatf("t2_gnt_%0d", k),      gv, 1 << (k % NUM_REQ));
      check($sformatf("t2_gnt_cyc_%0d", k),  gc, (k == 0) ? 1 : 2);
      check($sformatf("t2_en_%0d", k),       en, 2);
      check($sformatf("t2_done_cyc_%0d", k), dc, (k == 0) ? 5 : 6);
      check($sformatf("t2_done_%0d", k),     dv, 1 << (k % NUM_REQ));
    end
    bus.req = '0;
    tick();

    // 3: zero length run
    set_len(2, 0);
    bus.req = 4'b0100;
    run_watch(10, en, gc, gv, cc, dc, dv, cd, tc);
    check("t3_gnt",      gv, 4);
    check("t3_en_cnt",   en, 0);
    check("t3_done_cyc", dc, 3);
    check("t3_done",     dv, 4);
    bus.req = '0;
    tick();

    // 4: abort requester 1 after two counts, requester 2 takes over
    set_len(1, 9);
    set_len(2, 1);
    bus.req = 4'b0110;
    tick();
    check("t4_gnt", int'(bus.gnt), 2);
    hit = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cnt == 2) begin hit = 1; break; end
    end
    check("t4_reached_2", hit, 1);
    bus.req = 4'b0100;
    tick();
    check("t4_abort_gnt",  int'(bus.gnt),  0);
    check("t4_abort_done", int'(bus.done), 0);
    check("t4_abort_busy", int'(bus.busy), 0);
    tick();
    check("t4_next_gnt", int'(bus.gnt), 4);
    run_watch(10, en, gc, gv, cc, dc, dv, cd, tc);
    check("t4_done_cyc", dc, 3);
    check("t4_done",     dv, 4);
    check("t4_en_cnt",   en, 1);
    bus.req = '0;
    tick();

    // 5: async reset in the middle of a run
    set_len(0, 9);
    bus.req = 4'b0001;
    tick();
    check("t5_gnt", int'(bus.gnt), 1);
    hit = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cnt == 3) begin hit = 1; break; end
    end
    check("t5_reached_3", hit, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_gnt",  int'(bus.gnt),     0);
    check("t5_rst_en",   int'(bus.ctr_en),  0);
    check("t5_rst_busy", int'(bus.busy),    0);
    check("t5_rst_clr",  int'(bus.ctr_clr), 0);
    check("t5_rst_done", int'(bus.done),    0);
    bus.req = 4'b1001;
    set_len(0, 1);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("t5_restart_gnt", int'(bus.gnt), 1);
    run_watch(10, en, gc, gv, cc, dc, dv, cd, tc);
    check("t5_done", dv, 1);
    bus.req = '0;
    tick();

    // 6: counter stuck at 0
    stuck = 1'b1;
    set_len(0, 3);
    bus.req = 4'b0001;
    run_watch(30, en, gc, gv, cc, dc, dv, cd, tc);
    check("t6_gnt",      gv, 1);
    check("t6_no_done",  dc, -1);
`ifdef CTR_RUN_SCHED_TIMEOUT_EN
    check("t6_tmo_cyc",  tc, 19);
`else
    check("t6_no_tmo",   tc, -1);
    check("t6_busy",     int'(bus.busy), 1);
`endif
    bus.req = '0;
    tick();
    check("t6_abort_busy", int'(bus.busy), 0);
    stuck = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end
endmodule
